// File: rtl/fp_addsub_arbiter.sv
// Two-requester round-robin front end for a fixed-latency FP add/sub datapath.
// Issues one operation per cycle, tracks requester tags through the pipe and returns tagged results.
module fp_addsub_arbiter #(
  parameter int unsigned DataSize = 32,
  parameter int unsigned Latency  = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Req0Valid,
  output logic                Req0Ready,
  input  logic [DataSize-1:0] Req0Op1,
  input  logic [DataSize-1:0] Req0Op2,
  input  logic                Req0Operation,
  input  logic                Req1Valid,
  output logic                Req1Ready,
  input  logic [DataSize-1:0] Req1Op1,
  input  logic [DataSize-1:0] Req1Op2,
  input  logic                Req1Operation,
  input  logic                Flush,
  output logic                IssueValid,
  output logic [DataSize-1:0] IssueOp1,
  output logic [DataSize-1:0] IssueOp2,
  output logic                IssueOperation,
  input  logic [DataSize-1:0] PipeResult,
  output logic                Resp0Valid,
  output logic                Resp1Valid,
  output logic [DataSize-1:0] RespResult,
  output logic [3:0]          InFlight,
  output logic                Busy
);

  localparam int unsigned CntW = 4;

  // last_grant_q = 1 means requester 1 won last, so requester 0 wins the next contention
  logic                last_grant_q, last_grant_d;
  logic                grant0_c, grant1_c, accept_c, resp_fire_c;

  logic                issue_valid_q, issue_valid_d;
  logic [DataSize-1:0] issue_op1_q, issue_op1_d;
  logic [DataSize-1:0] issue_op2_q, issue_op2_d;
  logic                issue_operation_q, issue_operation_d;

  logic [Latency:0]    vld_q, vld_d;
  logic [Latency:0]    tag_q, tag_d;

  logic                resp0_valid_q, resp0_valid_d;
  logic                resp1_valid_q, resp1_valid_d;
  logic [DataSize-1:0] resp_result_q, resp_result_d;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic                busy_q, busy_d;

  // Round-robin grant; nothing is granted while flushing or in reset
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (!Reset && !Flush) begin
      if (Req0Valid && (!Req1Valid || last_grant_q)) begin
        grant0_c = 1'b1;
      end else if (Req1Valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign accept_c    = grant0_c | grant1_c;
  assign resp_fire_c = vld_q[Latency] & ~Flush;

  always_comb begin
    last_grant_d      = last_grant_q;
    issue_valid_d     = accept_c;
    issue_op1_d       = issue_op1_q;
    issue_op2_d       = issue_op2_q;
    issue_operation_d = issue_operation_q;
    vld_d             = {vld_q[Latency-1:0], accept_c};
    tag_d             = {tag_q[Latency-1:0], grant1_c};
    resp0_valid_d     = resp_fire_c & ~tag_q[Latency];
    resp1_valid_d     = resp_fire_c &  tag_q[Latency];
    resp_result_d     = resp_result_q;
    inflight_d        = inflight_q + CntW'(accept_c) - CntW'(resp_fire_c);

    if (accept_c) begin
      last_grant_d      = grant1_c;
      issue_op1_d       = grant1_c ? Req1Op1 : Req0Op1;
      issue_op2_d       = grant1_c ? Req1Op2 : Req0Op2;
      issue_operation_d = grant1_c ? Req1Operation : Req0Operation;
    end

    if (resp_fire_c) begin
      resp_result_d = PipeResult;
    end

    // Flush drops every tracked op; datapath results for them are never captured
    if (Flush) begin
      vld_d      = '0;
      inflight_d = '0;
    end

    busy_d = (inflight_d != '0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_grant_q      <= 1'b1;
      issue_valid_q     <= 1'b0;
      issue_op1_q       <= '0;
      issue_op2_q       <= '0;
      issue_operation_q <= 1'b0;
      vld_q             <= '0;
      tag_q             <= '0;
      resp0_valid_q     <= 1'b0;
      resp1_valid_q     <= 1'b0;
      resp_result_q     <= '0;
      inflight_q        <= '0;
      busy_q            <= 1'b0;
    end else begin
      last_grant_q      <= last_grant_d;
      issue_valid_q     <= issue_valid_d;
      issue_op1_q       <= issue_op1_d;
      issue_op2_q       <= issue_op2_d;
      issue_operation_q <= issue_operation_d;
      vld_q             <= vld_d;
      tag_q             <= tag_d;
      resp0_valid_q     <= resp0_valid_d;
      resp1_valid_q     <= resp1_valid_d;
      resp_result_q     <= resp_result_d;
      inflight_q        <= inflight_d;
      busy_q            <= busy_d;
    end
  end

  assign Req0Ready      = grant0_c;
  assign Req1Ready      = grant1_c;
  assign IssueValid     = issue_valid_q;
  assign IssueOp1       = issue_op1_q;
  assign IssueOp2       = issue_op2_q;
  assign IssueOperation = issue_operation_q;
  assign Resp0Valid     = resp0_valid_q;
  assign Resp1Valid     = resp1_valid_q;
  assign RespResult     = resp_result_q;
  assign InFlight       = inflight_q;
  assign Busy           = busy_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter with a 3-stage stand-in FP datapath.
module tb_fp_addsub_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  localparam logic [31:0] F1 = 32'h3F800000;  // 1.0
  localparam logic [31:0] F2 = 32'h40000000;  // 2.0
  localparam logic [31:0] F3 = 32'h40400000;  // 3.0
  localparam logic [31:0] F4 = 32'h40800000;  // 4.0

  logic          Clk, Reset, Flush;
  logic          Req0Valid, Req0Ready, Req0Operation;
  logic          Req1Valid, Req1Ready, Req1Operation;
  logic [DW-1:0] Req0Op1, Req0Op2, Req1Op1, Req1Op2;
  logic          IssueValid, IssueOperation;
  logic [DW-1:0] IssueOp1, IssueOp2, PipeResult, RespResult;
  logic          Resp0Valid, Resp1Valid, Busy;
  logic [3:0]    InFlight;

  int total = 0;
  int bad   = 0;

  fp_addsub_arbiter #(.DataSize(DW), .Latency(LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Op1(Req0Op1), .Req0Op2(Req0Op2),
    .Req0Operation(Req0Operation),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Op1(Req1Op1), .Req1Op2(Req1Op2),
    .Req1Operation(Req1Operation),
    .Flush(Flush),
    .IssueValid(IssueValid), .IssueOp1(IssueOp1), .IssueOp2(IssueOp2),
    .IssueOperation(IssueOperation),
    .PipeResult(PipeResult),
    .Resp0Valid(Resp0Valid), .Resp1Valid(Resp1Valid), .RespResult(RespResult),
    .InFlight(InFlight), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Known FP sums/differences used by the vectors; anything else returns a quiet NaN
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (!s && a == F1 && b == F2) return F3;
    if ( s && a == F3 && b == F1) return F2;
    if (!s && a == F2 && b == F2) return F4;
    if ( s && a == F4 && b == F1) return F3;
    return 32'h7FC00000;
  endfunction

  // Datapath samples the issue registers and presents the result LAT edges later
  logic [31:0] pm [LAT];
  always @(posedge Clk) begin
    pm[0] <= fp_model(IssueOp1, IssueOp2, IssueOperation);
    for (int i = 1; i < LAT; i++) pm[i] <= pm[i-1];
  end
  assign PipeResult = pm[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; Flush = 1'b0;
    Req0Valid = 1'b1; Req0Op1 = F1; Req0Op2 = F2; Req0Operation = 1'b0;
    Req1Valid = 1'b0; Req1Op1 = F3; Req1Op2 = F1; Req1Operation = 1'b1;

    // Reset state, checked before any clock edge
    #2 Reset = 1'b1;
    #1;
    chk("rst_ready0", Req0Ready, 0);
    chk("rst_issue_valid", IssueValid, 0);
    chk("rst_issue_op1", IssueOp1, 0);
    chk("rst_resp_result", RespResult, 0);
    chk("rst_inflight", InFlight, 0);
    chk("rst_busy", Busy, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    Req0Valid = 1'b0;

    // Both valid for 6 edges: grants alternate starting with 0, InFlight saturates at 4
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      int acc, rsp;
      if (k == 7) begin Req0Valid = 1'b0; Req1Valid = 1'b0; end
      #1;
      if (k <= 6) begin
        chk("rr_ready0", Req0Ready, (k % 2 == 1));
        chk("rr_ready1", Req1Ready, (k % 2 == 0));
      end
      step();
      acc = (k < 6) ? k : 6;
      rsp = (k > 4) ? k - 4 : 0;
      chk("rr_inflight", InFlight, acc - rsp);
      if (k <= 6) begin
        chk("rr_issue_valid", IssueValid, 1);
        chk("rr_issue_op1", IssueOp1, (k % 2 == 1) ? F1 : F3);
        chk("rr_issue_operation", IssueOperation, (k % 2 == 0));
      end
      if (k >= 5) begin
        chk("rr_resp0", Resp0Valid, (k % 2 == 1));
        chk("rr_resp1", Resp1Valid, (k % 2 == 0));
        chk("rr_result", RespResult, (k % 2 == 1) ? F3 : F2);
      end else begin
        chk("rr_noresp", {Resp1Valid, Resp0Valid}, 0);
      end
    end
    chk("rr_busy_idle", Busy, 0);

    // Single Req0 op 1.0 + 2.0: issue after edge 1, response after edge 5
    Req0Valid = 1'b1; Req0Op1 = F1; Req0Op2 = F2; Req0Operation = 1'b0;
    #1 chk("one_ready0", Req0Ready, 1);
    step();
    Req0Valid = 1'b0; Req0Op1 = 32'h12345678;
    chk("one_issue_valid", IssueValid, 1);
    chk("one_issue_op1", IssueOp1, F1);
    chk("one_issue_op2", IssueOp2, F2);
    chk("one_issue_operation", IssueOperation, 0);
    chk("one_inflight", InFlight, 1);
    chk("one_busy", Busy, 1);
    step();
    chk("one_issue_drop", IssueValid, 0);
    chk("one_issue_hold", IssueOp1, F1);
    step();
    step();
    chk("one_resp_early", Resp0Valid, 0);
    step();
    chk("one_resp0", Resp0Valid, 1);
    chk("one_resp1", Resp1Valid, 0);
    chk("one_result", RespResult, F3);
    chk("one_inflight_done", InFlight, 0);
    step();
    chk("one_resp0_pulse", Resp0Valid, 0);
    chk("one_result_hold", RespResult, F3);

    // Req1 wins alone, then contention goes to Req0
    Req1Valid = 1'b1; Req1Op1 = F4; Req1Op2 = F1; Req1Operation = 1'b1;
    #1 chk("rr1_ready1", Req1Ready, 1);
    step();
    Req0Valid = 1'b1; Req0Op1 = F1; Req0Op2 = F2; Req0Operation = 1'b0;
    #1;
    chk("rr1_both_ready0", Req0Ready, 1);
    chk("rr1_both_ready1", Req1Ready, 0);
    step();
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    chk("rr1_issue_op1", IssueOp1, F1);
    chk("rr1_inflight", InFlight, 2);
    for (int j = 3; j <= 6; j++) begin
      step();
      chk("rr1_resp1", Resp1Valid, (j == 5));
      chk("rr1_resp0", Resp0Valid, (j == 6));
      if (j >= 5) chk("rr1_result", RespResult, F3);
    end
    chk("rr1_inflight_done", InFlight, 0);

    // Flush with 3 operations in flight
    Req0Valid = 1'b1; Req0Op1 = F2; Req0Op2 = F2; Req0Operation = 1'b0;
    step(); step(); step();
    chk("fl_inflight_pre", InFlight, 3);
    Req1Valid = 1'b1; Flush = 1'b1;
    #1 chk("fl_ready", {Req1Ready, Req0Ready}, 0);
    step();
    Flush = 1'b0; Req0Valid = 1'b0; Req1Valid = 1'b0;
    chk("fl_inflight", InFlight, 0);
    chk("fl_busy", Busy, 0);
    chk("fl_issue_valid", IssueValid, 0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("fl_no_resp", {Resp1Valid, Resp0Valid}, 0);
      chk("fl_inflight_stay", InFlight, 0);
    end
    chk("fl_result_hold", RespResult, F3);

    // Reset between edges with work in flight, then Req1 alone
    Req0Valid = 1'b1; Req0Op1 = F1; Req0Op2 = F2; Req0Operation = 1'b0;
    step(); step();
    chk("mr_inflight_pre", InFlight, 2);
    #2 Reset = 1'b1;
    #1;
    chk("mr_ready0", Req0Ready, 0);
    chk("mr_issue_valid", IssueValid, 0);
    chk("mr_issue_op1", IssueOp1, 0);
    chk("mr_issue_op2", IssueOp2, 0);
    chk("mr_resp_result", RespResult, 0);
    chk("mr_inflight", InFlight, 0);
    chk("mr_busy", Busy, 0);
    @(negedge Clk);
    Reset = 1'b0; Req0Valid = 1'b0;
    Req1Valid = 1'b1; Req1Op1 = F2; Req1Op2 = F2; Req1Operation = 1'b0;
    #1 chk("mr_ready1", Req1Ready, 1);
    step();
    Req1Valid = 1'b0;
    chk("mr_issue_valid_post", IssueValid, 1);
    chk("mr_issue_op1_post", IssueOp1, F2);
    chk("mr_inflight_post", InFlight, 1);
    for (int j = 2; j <= 6; j++) begin
      step();
      chk("mr_resp0", Resp0Valid, 0);
      chk("mr_resp1", Resp1Valid, (j == 5));
      if (j == 5) chk("mr_result", RespResult, F4);
    end
    chk("mr_inflight_done", InFlight, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
